// File: rtl/round_robin_arbiter.sv
// Four-requester arbiter (A=bit3 .. D=bit0) with fixed-priority or round-robin selection and registered grants.
// Optional forced release after HOLD_MAX grant cycles when ARB_TIMEOUT_EN is defined.
module round_robin_arbiter #(
  parameter int HOLD_MAX = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic       done,
  input  logic       rr_en,
  output logic [3:0] gnt,
  output logic       W,
  output logic       Y,
  output logic       valid,
  output logic       timeout
);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e     state_q, state_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] idx_q, idx_d;
  logic       valid_q, valid_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] winIdx;
  logic       relNow;
  logic       holdExpired;

  if (HOLD_MAX < 1 || HOLD_MAX > 15) begin : gHoldMaxCheck
    $error("HOLD_MAX must be in 1..15");
  end

  // Lowest loop offset is applied last, so the first set bit at or below ptr wins.
  always_comb begin
    winIdx = 2'd0;
    if (rr_en) begin
      for (int k = 3; k >= 0; k--) begin
        if (req[ptr_q - 2'(k)]) winIdx = ptr_q - 2'(k);
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (req[k]) winIdx = 2'(k);
      end
    end
  end

  assign relNow = done | ~req[idx_q];

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = GRANT;
          gnt_d   = 4'b0001 << winIdx;
          idx_d   = winIdx;
          valid_d = 1'b1;
          ptr_d   = winIdx - 2'd1;
        end
      end
      GRANT: begin
        if (relNow || holdExpired) begin
          state_d = IDLE;
          gnt_d   = 4'b0000;
          idx_d   = 2'd0;
          valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q   <= 4'b0000;
      idx_q   <= 2'd0;
      valid_q <= 1'b0;
      ptr_q   <= 2'd3;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  logic [3:0] holdCnt_q, holdCnt_d;
  logic       timeout_q, timeout_d;

  assign holdExpired = (state_q == GRANT) && (holdCnt_q == 4'(HOLD_MAX - 1));

  // Counter sits at zero in IDLE so it starts clean on every grant; a normal release wins over the limit.
  always_comb begin
    holdCnt_d = (state_q == GRANT) ? holdCnt_q + 4'd1 : 4'd0;
    timeout_d = holdExpired && !relNow;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      holdCnt_q <= 4'd0;
      timeout_q <= 1'b0;
    end else begin
      holdCnt_q <= holdCnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign holdExpired = 1'b0;
  assign timeout     = 1'b0;
`endif

  assign gnt   = gnt_q;
  assign W     = idx_q[1];
  assign Y     = idx_q[0];
  assign valid = valid_q;

endmodule

// File: tb/tb_round_robin_arbiter.sv
// Directed, self-checking bench for round_robin_arbiter; expected values are hand-computed per step.
// Build with ARB_TIMEOUT_EN defined to exercise the forced-release path (HOLD_MAX=4).
module tb_round_robin_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic       done;
  logic       rr_en;
  logic [3:0] gnt;
  logic       W;
  logic       Y;
  logic       valid;
  logic       timeout;

  int vectors = 0;
  int miscompares = 0;

  round_robin_arbiter #(.HOLD_MAX(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .done    (done),
    .rr_en   (rr_en),
    .gnt     (gnt),
    .W       (W),
    .Y       (Y),
    .valid   (valid),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  // Drive inputs, take one rising edge, then settle 1 time unit before any check.
  task automatic applyStimulus(input logic rst, input logic [3:0] r, input logic d, input logic rr);
    reset = rst;
    req   = r;
    done  = d;
    rr_en = rr;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [3:0] expGnt, input logic [1:0] expWY,
                             input logic expTo);
    logic expValid;
    expValid = (expGnt != 4'b0000);
    vectors++;
    assert ({gnt, W, Y, valid, timeout} === {expGnt, expWY, expValid, expTo})
    else begin
      miscompares++;
      $error("[TB] FAIL %s: got gnt=%b WY=%b%b valid=%b timeout=%b, expected gnt=%b WY=%b valid=%b timeout=%b",
             tag, gnt, W, Y, valid, timeout, expGnt, expWY, expValid, expTo);
    end
  endtask

  initial begin
    reset = 1'b1;
    req   = 4'b0000;
    done  = 1'b0;
    rr_en = 1'b0;

    applyStimulus(1, 4'b0000, 0, 1); checkOutput("reset_idle", 4'b0000, 2'b00, 0);
    applyStimulus(1, 4'b1111, 0, 1); checkOutput("reset_blocks_grant", 4'b0000, 2'b00, 0);
    applyStimulus(0, 4'b0000, 0, 1); checkOutput("idle_no_req", 4'b0000, 2'b00, 0);

    applyStimulus(0, 4'b1111, 0, 1); checkOutput("rr_A", 4'b1000, 2'b11, 0);
    applyStimulus(0, 4'b1111, 1, 1); checkOutput("rr_dead1", 4'b0000, 2'b00, 0);
    applyStimulus(0, 4'b1111, 0, 1); checkOutput("rr_B", 4'b0100, 2'b10, 0);
    applyStimulus(0, 4'b1111, 1, 1); checkOutput("rr_dead2", 4'b0000, 2'b00, 0);
    applyStimulus(0, 4'b1111, 0, 1); checkOutput("rr_C", 4'b0010, 2'b01, 0);
    applyStimulus(0, 4'b1111, 1, 1); checkOutput("rr_dead3", 4'b0000, 2'b00, 0);
    applyStimulus(0, 4'b1111, 0, 1); checkOutput("rr_D", 4'b0001, 2'b00, 0);
    applyStimulus(0, 4'b1111, 1, 1); checkOutput("rr_dead4", 4'b0000, 2'b00, 0);
    applyStimulus(0, 4'b1111, 0, 1); checkOutput("rr_A_again", 4'b1000, 2'b11, 0);
    applyStimulus(0, 4'b1111, 1, 1); checkOutput("rr_dead5", 4'b0000, 2'b00, 0);

    applyStimulus(0, 4'b1111, 0, 1); checkOutput("pre_reset_B", 4'b0100, 2'b10, 0);
    applyStimulus(1, 4'b1111, 0, 1); checkOutput("reset_mid_grant", 4'b0000, 2'b00, 0);
    applyStimulus(0, 4'b1111, 0, 1); checkOutput("ptr_reset_A", 4'b1000, 2'b11, 0);
    applyStimulus(0, 4'b1111, 1, 1); checkOutput("rel_after_reset", 4'b0000, 2'b00, 0);

    applyStimulus(0, 4'b1111, 0, 0); checkOutput("fixed_A1", 4'b1000, 2'b11, 0);
    applyStimulus(0, 4'b1111, 1, 0); checkOutput("fixed_dead1", 4'b0000, 2'b00, 0);
    applyStimulus(0, 4'b1111, 0, 0); checkOutput("fixed_A2", 4'b1000, 2'b11, 0);
    applyStimulus(0, 4'b1111, 1, 0); checkOutput("fixed_dead2", 4'b0000, 2'b00, 0);
    applyStimulus(0, 4'b1111, 0, 0); checkOutput("fixed_A3", 4'b1000, 2'b11, 0);
    applyStimulus(0, 4'b1111, 1, 0); checkOutput("fixed_dead3", 4'b0000, 2'b00, 0);
    applyStimulus(0, 4'b0110, 0, 0); checkOutput("fixed_B", 4'b0100, 2'b10, 0);
    applyStimulus(0, 4'b0110, 1, 0); checkOutput("fixed_dead4", 4'b0000, 2'b00, 0);

    applyStimulus(0, 4'b0010, 0, 0); checkOutput("latency_C", 4'b0010, 2'b01, 0);
    applyStimulus(0, 4'b0000, 0, 0); checkOutput("req_drop", 4'b0000, 2'b00, 0);

    applyStimulus(0, 4'b0010, 0, 0); checkOutput("stab_C", 4'b0010, 2'b01, 0);
    applyStimulus(0, 4'b1110, 0, 0); checkOutput("stab_hold1", 4'b0010, 2'b01, 0);
    applyStimulus(0, 4'b1110, 0, 0); checkOutput("stab_hold2", 4'b0010, 2'b01, 0);
    applyStimulus(0, 4'b1110, 1, 0); checkOutput("stab_done", 4'b0000, 2'b00, 0);

    applyStimulus(0, 4'b1010, 0, 1); checkOutput("rr_wrap_A", 4'b1000, 2'b11, 0);
    applyStimulus(0, 4'b1010, 1, 1); checkOutput("rr_wrap_dead", 4'b0000, 2'b00, 0);
    applyStimulus(0, 4'b1010, 0, 1); checkOutput("rr_skip_C", 4'b0010, 2'b01, 0);
    applyStimulus(0, 4'b1010, 1, 1); checkOutput("rr_skip_dead", 4'b0000, 2'b00, 0);

`ifdef ARB_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 4'b0001, 0, 1); checkOutput("to_hold_D", 4'b0001, 2'b00, 0);
    end
    applyStimulus(0, 4'b0001, 0, 1); checkOutput("to_forced", 4'b0000, 2'b00, 1);
    applyStimulus(0, 4'b0001, 0, 1); checkOutput("to_regrant_D", 4'b0001, 2'b00, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 4'b0001, 0, 1); checkOutput("to_hold2_D", 4'b0001, 2'b00, 0);
    end
    applyStimulus(0, 4'b0001, 1, 1); checkOutput("to_done_at_limit", 4'b0000, 2'b00, 0);
`else
    for (int i = 0; i < 12; i++) begin
      applyStimulus(0, 4'b0001, 0, 1); checkOutput("no_to_hold_D", 4'b0001, 2'b00, 0);
    end
    applyStimulus(0, 4'b0001, 1, 1); checkOutput("no_to_release", 4'b0000, 2'b00, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
